// File: rtl/snake_dir_queue.sv
// snake_dir_queue: per-player buffered turn queue with reversal rejection, one turn committed per movement step.
module snake_dir_queue #(
    parameter int NUM_PLAYERS = 2,
    parameter int QUEUE_DEPTH = 2,
    parameter logic [7:0] KEY_W = 8'h1D,
    parameter logic [7:0] KEY_A = 8'h1C,
    parameter logic [7:0] KEY_S = 8'h1B,
    parameter logic [7:0] KEY_D = 8'h23,
    parameter logic [7:0] KEY_I = 8'h43,
    parameter logic [7:0] KEY_J = 8'h3B,
    parameter logic [7:0] KEY_K = 8'h42,
    parameter logic [7:0] KEY_L = 8'h4B,
    parameter logic [1:0] START_DIR0 = 2'b10,
    parameter logic [1:0] START_DIR1 = 2'b01
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               key,
    input  logic                     key_pressed,
    input  logic                     step_tick,
    output logic [2*NUM_PLAYERS-1:0] snake_dir,
    output logic [NUM_PLAYERS-1:0]   dir_changed,
    output logic [NUM_PLAYERS-1:0]   key_dropped,
    output logic [3*NUM_PLAYERS-1:0] queue_level
);
    localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
        localparam logic [7:0] KU = p == 0 ? KEY_W : KEY_I;
        localparam logic [7:0] KL = p == 0 ? KEY_A : KEY_J;
        localparam logic [7:0] KD = p == 0 ? KEY_S : KEY_K;
        localparam logic [7:0] KR = p == 0 ? KEY_D : KEY_L;
        localparam logic [1:0] SD = p == 0 ? START_DIR0 : START_DIR1;
        logic [1:0] q [QUEUE_DEPTH];
        logic [PW-1:0] rd, wr, wr_last;
        logic [2:0] level, level_pop;
        logic [1:0] dir, cand, head, ref_dir;
        logic hit, pop, push, drop, changed, dropped;
        always_comb begin
            hit = key_pressed && (key == KU || key == KL || key == KD || key == KR);
            cand = key == KU ? 2'b00 : key == KL ? 2'b01 : key == KD ? 2'b11 : 2'b10;
            pop = step_tick && level != '0;
            head = q[rd];
            level_pop = level - {2'b0, pop};
            wr_last = wr == '0 ? LAST : wr - PW'(1);
            // new keys are judged against the newest turn that will still be pending
            ref_dir = level_pop != '0 ? q[wr_last] : pop ? head : dir;
            push = hit && cand != ref_dir && cand != ~ref_dir && level_pop < 3'(QUEUE_DEPTH);
            drop = hit && cand != ref_dir && !push;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                rd <= '0;
                wr <= '0;
                level <= '0;
                dir <= '0;
                changed <= 1'b0;
                dropped <= 1'b0;
            end else if (start) begin
                rd <= '0;
                wr <= '0;
                level <= '0;
                dir <= SD;
                changed <= 1'b0;
                dropped <= 1'b0;
            end else begin
                if (pop) rd <= rd == LAST ? '0 : rd + PW'(1);
                if (push) begin
                    q[wr] <= cand;
                    wr <= wr == LAST ? '0 : wr + PW'(1);
                end
                level <= level_pop + {2'b0, push};
                if (pop) dir <= head;
                changed <= pop && head != dir;
                dropped <= drop;
            end
        end
        assign snake_dir[2*p +: 2] = dir;
        assign queue_level[3*p +: 3] = level;
        assign dir_changed[p] = changed;
        assign key_dropped[p] = dropped;
    end
endmodule

// File: tb/tb_snake_dir_queue.sv
// tb_snake_dir_queue: random and directed stimulus checked against a queue-based reference model.
module tb_snake_dir_queue;
    localparam int NP = 2;
    localparam int D = 2;
    localparam logic [7:0] CODES [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h43, 8'h3B, 8'h42, 8'h4B};
    localparam logic [1:0] DIRS [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, key_pressed = 1'b0, step_tick = 1'b0;
    logic [7:0] key = 8'h00;
    logic [2*NP-1:0] snake_dir;
    logic [NP-1:0] dir_changed, key_dropped;
    logic [3*NP-1:0] queue_level;
    int n_checks = 0, n_fail = 0;
    logic [1:0] m_dir [NP];
    logic [1:0] m_q [NP][$];
    logic m_chg [NP];
    logic m_drop [NP];

    snake_dir_queue #(.NUM_PLAYERS(NP), .QUEUE_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .key_pressed(key_pressed),
        .step_tick(step_tick), .snake_dir(snake_dir), .dir_changed(dir_changed),
        .key_dropped(key_dropped), .queue_level(queue_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int key_player(input logic [7:0] k, output logic [1:0] c);
        c = 2'b00;
        for (int i = 0; i < 8; i++)
            if (k == CODES[i]) begin
                c = DIRS[i % 4];
                return i / 4;
            end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic kp, input logic st, input logic [7:0] k);
        int pl;
        logic [1:0] c, rf;
        pl = kp ? key_player(k, c) : -1;
        for (int p = 0; p < NP; p++) begin
            m_chg[p] = 1'b0;
            m_drop[p] = 1'b0;
            if (r) begin
                m_dir[p] = 2'b00;
                m_q[p].delete();
            end else if (s) begin
                m_dir[p] = p == 0 ? 2'b10 : 2'b01;
                m_q[p].delete();
            end else begin
                if (st && m_q[p].size() > 0) begin
                    c = m_q[p].pop_front();
                    m_chg[p] = c != m_dir[p];
                    m_dir[p] = c;
                end
                if (pl == p) begin
                    void'(key_player(k, c));
                    rf = m_q[p].size() > 0 ? m_q[p][$] : m_dir[p];
                    if (c == rf) ;
                    else if (c == ~rf) m_drop[p] = 1'b1;
                    else if (m_q[p].size() >= D) m_drop[p] = 1'b1;
                    else m_q[p].push_back(c);
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic kp, input logic st, input logic [7:0] k);
        logic [2*NP-1:0] ed;
        logic [3*NP-1:0] el;
        logic [NP-1:0] ec, ek;
        rst = r; start = s; key_pressed = kp; step_tick = st; key = k;
        @(posedge clk);
        model_step(r, s, kp, st, k);
        #1;
        for (int p = 0; p < NP; p++) begin
            ed[2*p +: 2] = m_dir[p];
            el[3*p +: 3] = 3'(m_q[p].size());
            ec[p] = m_chg[p];
            ek[p] = m_drop[p];
        end
        check("snake_dir", 32'(snake_dir), 32'(ed));
        check("queue_level", 32'(queue_level), 32'(el));
        check("dir_changed", 32'(dir_changed), 32'(ec));
        check("key_dropped", 32'(key_dropped), 32'(ek));
        rst = 1'b0; start = 1'b0; key_pressed = 1'b0; step_tick = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, k);
    endtask

    task automatic step();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic go();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("reset_dir", 32'(snake_dir), 32'h0);
        go();
        check("start_dir", 32'(snake_dir), 32'h6);
        step();
        check("empty_step_chg", 32'(dir_changed), 32'h0);
        press(8'h1D);
        step();
        check("w_commit", 32'(snake_dir[1:0]), 32'h0);
        check("w_changed", 32'(dir_changed), 32'h1);
        step();
        check("chg_one_cycle", 32'(dir_changed), 32'h0);
        go();
        press(8'h1C);
        check("reversal_drop", 32'(key_dropped), 32'h1);
        check("reversal_level", 32'(queue_level[2:0]), 32'h0);
        step();
        check("reversal_keeps", 32'(snake_dir[1:0]), 32'h2);
        go();
        press(8'h1D);
        press(8'h1C);
        check("wa_level", 32'(queue_level[2:0]), 32'h2);
        step();
        check("wa_first", 32'(snake_dir[1:0]), 32'h0);
        step();
        check("wa_second", 32'(snake_dir[1:0]), 32'h1);
        go();
        press(8'h1D);
        press(8'h1C);
        press(8'h1B);
        check("full_drop", 32'(key_dropped), 32'h1);
        check("full_level", 32'(queue_level[2:0]), 32'h2);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h1B);
        check("pop_push_level", 32'(queue_level[2:0]), 32'h2);
        check("pop_push_nodrop", 32'(key_dropped), 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h1B);
        press(8'h3B);
        press(8'h1D);
        press(8'h3B);
        press(8'h1D);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h43);
        check("start_flush_dir", 32'(snake_dir), 32'h6);
        check("start_flush_lvl", 32'(queue_level), 32'h0);
        for (int i = 0; i < 4000; i++) begin
            logic r, s, kp, st;
            logic [7:0] k;
            r = $urandom_range(0, 599) == 0;
            s = $urandom_range(0, 149) == 0;
            kp = $urandom_range(0, 1) == 1;
            st = $urandom_range(0, 2) == 0;
            k = $urandom_range(0, 7) == 0 ? 8'($urandom) : CODES[$urandom_range(0, 7)];
            cycle(r, s, kp, st, k);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/snake_dir_queue.md
Name: snake_dir_queue

Overview:
Per-player snake direction controller with a buffered turn queue and reversal rejection. It sits between the PS/2 key decoder (key/key_pressed) and the snake movement engine. Key presses are queued per player, and one turn is committed per movement step, so fast double-taps are not lost. A 180-degree turn into the snake's own body is never committed. It generalises the single-player direct-write direction register to N players with configurable queue depth.

Parameters:
NUM_PLAYERS, 2, number of snakes (legal 1..2); player 0 uses W/A/S/D, player 1 uses I/J/K/L.
QUEUE_DEPTH, 2, pending turns buffered per player (legal 1..4).
KEY_W, 8'h1D / KEY_A, 8'h1C / KEY_S, 8'h1B / KEY_D, 8'h23, player 0 scan codes (PS/2 set 2).
KEY_I, 8'h43 / KEY_J, 8'h3B / KEY_K, 8'h42 / KEY_L, 8'h4B, player 1 scan codes.
START_DIR0, 2'b10, player 0 direction loaded on start (right).
START_DIR1, 2'b01, player 1 direction loaded on start (left).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  game start pulse; flushes queues and loads start directions.
key  input  8  scan code, valid when key_pressed=1.
key_pressed  input  1  one-cycle make-code strobe.
step_tick  input  1  one-cycle pulse, snake engine advances one cell this cycle.
snake_dir  output  2*NUM_PLAYERS  committed direction; player p at [2p+1:2p].
dir_changed  output  NUM_PLAYERS  one-cycle pulse when player p's snake_dir changes value.
key_dropped  output  NUM_PLAYERS  one-cycle pulse when a mapped key for player p is rejected.
queue_level  output  3*NUM_PLAYERS  pending entries for player p at [3p+2:3p] (0..QUEUE_DEPTH).

Behaviour:
- Direction encoding: 00 up, 01 left, 11 down, 10 right. The opposite of direction d is ~d (bitwise).
- Key map: W/I=00, A/J=01, S/K=11, D/L=10. Unmapped codes and player-1 codes when NUM_PLAYERS=1 are ignored, with no drop pulse.
- Priority per cycle: rst > start > (step_tick pop, then key push).
- Reset: snake_dir=0, queues empty, queue_level=0, dir_changed=0, key_dropped=0.
- start: each queue flushed, snake_dir[p]=START_DIRp, no dir_changed or key_dropped pulse, and any same-cycle key/step ignored.
- Reference direction ref[p] = newest queued entry after this cycle's pop. If the queue is empty after the pop, ref[p] is the snake_dir value being committed this cycle.
- Push: a mapped key for player p with candidate c:
  - c==ref[p] (duplicate) -> discarded silently, no drop pulse;
  - c==~ref[p] (reversal) -> discarded, key_dropped[p]=1 next cycle;
  - queue full after pop -> discarded, key_dropped[p]=1;
  - otherwise appended; queue_level increments next cycle.
- Pop: on step_tick with queue non-empty, the head is written to snake_dir[p] and becomes visible the cycle after the step_tick. dir_changed[p] pulses in that same cycle. A step_tick with an empty queue leaves snake_dir unchanged, with no pulse.
- Latency: a key pressed in cycle n is committable by a step_tick in cycle n+1. A key and a step_tick in the same cycle on an empty queue do not commit this step; the key is queued, with ref = current snake_dir.
- Simultaneous pop and push with a full queue: the pop frees a slot, so the push succeeds and the level is unchanged.
- The queue is a circular buffer; read/write pointers wrap modulo QUEUE_DEPTH. Level never exceeds QUEUE_DEPTH and never underflows.
- Pulse outputs are registered and last exactly one cycle.
- Players are fully independent: same-cycle activity on one player never affects another.
- A reset asserted mid-game clears all state in the next cycle regardless of pending steps.

Test Plan:
- rst, then start -> snake_dir = {01,10}, queue_level=0; step_tick with empty queues -> no change, dir_changed=0.
- P0 heading right (10): key W, then step_tick -> snake_dir[1:0]=00 one cycle after step, dir_changed[0]=1 for one cycle.
- P0 heading right: key A (01, reversal) -> key_dropped[0]=1, queue_level[0] stays 0, next step keeps 10.
- P0 heading right: W then A within one step period -> queue holds 00,01 (A checked against W, accepted); two step_ticks -> 00 then 01.
- QUEUE_DEPTH=2: W, A, S with no step -> third key (S vs ref 01) pushed? No: the queue is full, so key_dropped[0]=1 and queue_level=2. Then step_tick plus key S in the same cycle -> S accepted, queue_level stays 2.
- P1 key J while P0 gets W in alternate cycles, start asserted together with key I -> queues flushed, I ignored, snake_dir={01,10}.
